// File: rtl/i2c_wb_cmd_seq.sv
// Wishbone command sequencer for the IICMB I2C core: runs one write transfer
// (bus select, START, address, data bytes, STOP) from a request and a byte FIFO.
module i2c_wb_cmd_seq #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int IRQ_TIMEOUT   = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [3:0]               req_bus_i,
  input  logic [6:0]               req_addr_i,
  input  logic [2:0]               req_len_i,
  input  logic                     wdata_valid_i,
  input  logic [7:0]               wdata_i,
  output logic                     wdata_ready_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [1:0]               err_code_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = (IRQ_TIMEOUT > 1) ? $clog2(IRQ_TIMEOUT) : 1;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IRQ_TIMEOUT - 1);
  localparam logic [3:0]       LEN_MAX  = (FIFO_DEPTH > 7) ? 4'd7 : 4'(FIFO_DEPTH);

  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

  localparam logic [7:0] CSR_ENABLE  = 8'hC0;
  localparam logic [7:0] CMD_SET_BUS = 8'h06;
  localparam logic [7:0] CMD_START   = 8'h04;
  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_STOP    = 8'h05;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_NAK  = 2'd1;
  localparam logic [1:0] ERR_CORE = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [3:0] {
    INIT, IDLE, SET_BUS, START, ADDR, DATA, STOP, WAIT_IRQ, CHK, DONE
  } state_t;

  function automatic logic [3:0] sat_len(input logic [2:0] len);
    if (len == 3'd0) return 4'd1;
    if ({1'b0, len} > LEN_MAX) return LEN_MAX;
    return {1'b0, len};
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [WB_DATA_WIDTH-1:0] wb_byte(input logic [7:0] b);
    return WB_DATA_WIDTH'(b);
  endfunction

  // Write-data FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_push  = wdata_valid_i & ~fifo_full;

  always_ff @(posedge clk_i) begin
    if (rst_i || fifo_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Sequencer state and Wishbone master registers
  state_t                   state_q, state_d, next_q, next_d;
  logic                     step_q, step_d;
  logic [3:0]               bus_q, bus_d;
  logic [6:0]               addr_q, addr_d;
  logic [3:0]               left_q, left_d;
  logic [1:0]               err_q, err_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     cyc_q, cyc_d, we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;

  logic                     wb_done;
  logic                     req_go, req_we;
  logic [WB_ADDR_WIDTH-1:0] req_adr;
  logic [WB_DATA_WIDTH-1:0] req_dat;
  logic                     to_wait;
  state_t                   wait_next;
  logic                     unused_dat;

  assign wb_done    = cyc_q & ack_i;
  assign unused_dat = ^dat_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      step_q  <= 1'b0;
      err_q   <= ERR_NONE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    next_q <= next_d;
    bus_q  <= bus_d;
    addr_q <= addr_d;
    left_q <= left_d;
    tmo_q  <= tmo_d;
  end

  always_comb begin
    state_d    = state_q;
    next_d     = next_q;
    step_d     = step_q;
    bus_d      = bus_q;
    addr_d     = addr_q;
    left_d     = left_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    req_go     = 1'b0;
    req_we     = 1'b1;
    req_adr    = ADR_CSR;
    req_dat    = '0;
    to_wait    = 1'b0;
    wait_next  = IDLE;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    case (state_q)
      INIT: begin
        req_go  = 1'b1;
        req_dat = wb_byte(CSR_ENABLE);
        if (wb_done) state_d = IDLE;
      end
      IDLE: begin
        if (req_valid_i) begin
          bus_d   = req_bus_i;
          addr_d  = req_addr_i;
          left_d  = sat_len(req_len_i);
          err_d   = ERR_NONE;
          step_d  = 1'b0;
          state_d = SET_BUS;
        end
      end
      SET_BUS: begin
        req_go = 1'b1;
        if (!step_q) begin
          req_adr = ADR_DPR;
          req_dat = wb_byte({4'd0, bus_q});
          if (wb_done) step_d = 1'b1;
        end else begin
          req_adr   = ADR_CMDR;
          req_dat   = wb_byte(CMD_SET_BUS);
          to_wait   = wb_done;
          wait_next = START;
        end
      end
      START: begin
        req_go    = 1'b1;
        req_adr   = ADR_CMDR;
        req_dat   = wb_byte(CMD_START);
        to_wait   = wb_done;
        wait_next = ADDR;
      end
      ADDR: begin
        req_go = 1'b1;
        if (!step_q) begin
          req_adr = ADR_DPR;
          req_dat = wb_byte({addr_q, 1'b0});
          if (wb_done) step_d = 1'b1;
        end else begin
          req_adr   = ADR_CMDR;
          req_dat   = wb_byte(CMD_WRITE);
          to_wait   = wb_done;
          wait_next = DATA;
        end
      end
      DATA: begin
        // An empty FIFO simply stalls here before the DPR write is launched.
        if (!step_q) begin
          req_go  = ~fifo_empty;
          req_adr = ADR_DPR;
          req_dat = wb_byte(mem_q[rd_ptr_q]);
          if (wb_done) begin
            fifo_pop = 1'b1;
            step_d   = 1'b1;
          end
        end else begin
          req_go    = 1'b1;
          req_adr   = ADR_CMDR;
          req_dat   = wb_byte(CMD_WRITE);
          to_wait   = wb_done;
          wait_next = (left_q == 4'd1) ? STOP : DATA;
          if (wb_done) left_d = left_q - 4'd1;
        end
      end
      STOP: begin
        req_go    = 1'b1;
        req_adr   = ADR_CMDR;
        req_dat   = wb_byte(CMD_STOP);
        to_wait   = wb_done;
        wait_next = DONE;
      end
      WAIT_IRQ: begin
        if (irq_i) begin
          state_d = CHK;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = ERR_TMO;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      CHK: begin
        req_go  = 1'b1;
        req_we  = 1'b0;
        req_adr = ADR_CMDR;
        if (wb_done) begin
          if (dat_i[7]) begin
            state_d = next_q;
          end else if (dat_i[6]) begin
            // A NAK still gets a STOP on the bus unless the STOP itself failed.
            err_d   = ERR_NAK;
            state_d = (next_q == DONE) ? DONE : STOP;
          end else begin
            err_d   = ERR_CORE;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        fifo_flush = (err_q != ERR_NONE);
        state_d    = IDLE;
      end
      default: state_d = INIT;
    endcase

    if (to_wait) begin
      state_d = WAIT_IRQ;
      next_d  = wait_next;
      tmo_d   = '0;
      step_d  = 1'b0;
    end

    if (wb_done) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
    end else if (req_go && !cyc_q) begin
      cyc_d = 1'b1;
      we_d  = req_we;
      adr_d = req_adr;
      dat_d = req_dat;
    end
  end

  assign cyc_o         = cyc_q & ~rst_i;
  assign stb_o         = cyc_q & ~rst_i;
  assign we_o          = we_q & ~rst_i;
  assign adr_o         = rst_i ? '0 : adr_q;
  assign dat_o         = rst_i ? '0 : dat_q;
  assign req_ready_o   = ~rst_i & (state_q == IDLE);
  assign busy_o        = ~rst_i & (state_q != IDLE);
  assign done_o        = ~rst_i & (state_q == DONE);
  assign err_o         = done_o & (err_q != ERR_NONE);
  assign err_code_o    = rst_i ? ERR_NONE : err_q;
  assign wdata_ready_o = rst_i | ~fifo_full;

endmodule

// File: tb/tb_i2c_wb_cmd_seq.sv
// Directed bench for i2c_wb_cmd_seq with a Wishbone/IICMB responder model.
module tb_i2c_wb_cmd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_bus = '0;
  logic [6:0] req_addr = '0;
  logic [2:0] req_len = '0;
  logic       wdata_valid = 1'b0;
  logic [7:0] wdata = '0;
  logic       wdata_ready;
  logic       cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] dat_o_w;
  logic [7:0] dat_i_r = '0;
  logic       ack = 1'b0;
  logic       irq = 1'b0;
  logic       busy, done, err;
  logic [1:0] err_code;

  i2c_wb_cmd_seq #(
    .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .FIFO_DEPTH(4), .IRQ_TIMEOUT(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_bus_i(req_bus),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .wdata_valid_i(wdata_valid), .wdata_i(wdata), .wdata_ready_o(wdata_ready),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o_w),
    .dat_i(dat_i_r), .ack_i(ack), .irq_i(irq),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responder: single-cycle acks, CMDR-read status from a table (default DON),
  // irq raised a few cycles after each CMDR write and cleared by the CMDR read.
  logic [10:0] wb_log[$];
  logic [7:0]  resp_mem [8];
  int          resp_wr = 0;
  int          resp_rd = 0;
  bit          hold_en = 1'b0;
  logic [7:0]  hold_dat = '0;
  bit          irq_en = 1'b1;
  int          irq_cnt = 0;
  int          wait_entry = 0;
  logic        prev_cyc = 1'b0;

  always @(negedge clk) begin
    if (cyc && stb && !ack && !(hold_en && we && adr == 2'd1 && dat_o_w == hold_dat)) begin
      check("wb_idle_gap", 32'(prev_cyc), 0);
      ack = 1'b1;
      if (we) begin
        wb_log.push_back({1'b1, adr, dat_o_w});
        if (adr == 2'd2) begin
          wait_entry = cyc_cnt + 1;
          if (irq_en) irq_cnt = 3;
        end
      end else begin
        if (resp_rd < resp_wr) begin
          dat_i_r = resp_mem[resp_rd];
          resp_rd++;
        end else begin
          dat_i_r = 8'h80;
        end
        wb_log.push_back({1'b0, adr, 8'h00});
        if (adr == 2'd2) irq = 1'b0;
      end
    end else begin
      ack = 1'b0;
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) irq = 1'b1;
      end
    end
    prev_cyc = cyc;
  end

  int log_idx = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_wb(input string tag, input logic w, input logic [1:0] a, input logic [7:0] d);
    int t = 0;
    while (wb_log.size() <= log_idx && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (wb_log.size() <= log_idx) begin
      check({tag, "_missing"}, 32'(wb_log.size()), 32'(log_idx + 1));
    end else begin
      check(tag, 32'(wb_log[log_idx]), 32'({w, a, d}));
      log_idx++;
    end
  endtask

  task automatic expect_head(input string tag, input logic [3:0] b, input logic [6:0] a);
    expect_wb({tag, "_dpr_bus"}, 1'b1, 2'd1, {4'd0, b});
    expect_wb({tag, "_cmd_setbus"}, 1'b1, 2'd2, 8'h06);
    expect_wb({tag, "_chk1"}, 1'b0, 2'd2, 8'h00);
    expect_wb({tag, "_cmd_start"}, 1'b1, 2'd2, 8'h04);
    expect_wb({tag, "_chk2"}, 1'b0, 2'd2, 8'h00);
    expect_wb({tag, "_dpr_addr"}, 1'b1, 2'd1, {a, 1'b0});
    expect_wb({tag, "_cmd_addr"}, 1'b1, 2'd2, 8'h01);
    expect_wb({tag, "_chk3"}, 1'b0, 2'd2, 8'h00);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b);
    expect_wb({tag, "_dpr"}, 1'b1, 2'd1, b);
    expect_wb({tag, "_cmd"}, 1'b1, 2'd2, 8'h01);
    expect_wb({tag, "_chk"}, 1'b0, 2'd2, 8'h00);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    wdata = b;
    wdata_valid = 1'b1;
    while (wdata_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    wdata_valid = 1'b0;
  endtask

  task automatic send_req(input logic [3:0] b, input logic [6:0] a, input logic [2:0] l);
    int t = 0;
    req_bus = b;
    req_addr = a;
    req_len = l;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_idle", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    check("errcode_cleared_on_accept", 32'(err_code), 0);
  endtask

  task automatic wait_done(input string tag, input logic [1:0] code, output int done_cyc);
    int t = 0;
    while (done !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    done_cyc = cyc_cnt;
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_err"}, 32'(err), (code != 2'd0) ? 1 : 0);
    check({tag, "_err_code"}, 32'(err_code), 32'(code));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_err_code_held"}, 32'(err_code), 32'(code));
    check({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int dc;
    int sz;
    int t;

    // Reset state
    tick(1);
    check("rst_cyc", 32'(cyc), 0);
    check("rst_stb", 32'(stb), 0);
    check("rst_we", 32'(we), 0);
    check("rst_adr", 32'(adr), 0);
    check("rst_dat", 32'(dat_o_w), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_wdata_ready", 32'(wdata_ready), 1);
    tick(2);
    rst = 1'b0;
    expect_wb("init_csr", 1'b1, 2'd0, 8'hC0);

    // FIFO fill to depth, fifth push stalls
    push_byte(8'h78);
    push_byte(8'h08);
    push_byte(8'h18);
    check("fifo_not_full_3", 32'(wdata_ready), 1);
    push_byte(8'hAA);
    check("fifo_full_4", 32'(wdata_ready), 0);
    wdata = 8'h55;
    wdata_valid = 1'b1;
    tick(3);
    check("fifo_push5_stalled", 32'(wdata_ready), 0);
    wdata_valid = 1'b0;
    check("idle_ready", 32'(req_ready), 1);
    check("idle_busy", 32'(busy), 0);

    // Nominal transfer
    send_req(4'd5, 7'h22, 3'd4);
    expect_head("nom", 4'd5, 7'h22);
    expect_byte("nom_b0", 8'h78);
    expect_byte("nom_b1", 8'h08);
    expect_byte("nom_b2", 8'h18);
    expect_byte("nom_b3", 8'hAA);
    expect_wb("nom_stop", 1'b1, 2'd2, 8'h05);
    expect_wb("nom_chk_stop", 1'b0, 2'd2, 8'h00);
    wait_done("nom", 2'd0, dc);
    check("nom_fifo_drained", 32'(wdata_ready), 1);

    // len=0 sends one byte; DATA waits on an empty FIFO
    send_req(4'd7, 7'h10, 3'd0);
    expect_head("len0", 4'd7, 7'h10);
    sz = wb_log.size();
    tick(10);
    check("data_hold_empty", 32'(wb_log.size()), 32'(sz));
    check("data_hold_busy", 32'(busy), 1);
    push_byte(8'h3C);
    expect_byte("len0_b0", 8'h3C);
    expect_wb("len0_stop", 1'b1, 2'd2, 8'h05);
    expect_wb("len0_chk_stop", 1'b0, 2'd2, 8'h00);
    wait_done("len0", 2'd0, dc);

    // Address NAK: STOP still issued, FIFO flushed
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    check("nak_fifo_full", 32'(wdata_ready), 0);
    resp_mem[resp_wr] = 8'h80; resp_wr++;
    resp_mem[resp_wr] = 8'h80; resp_wr++;
    resp_mem[resp_wr] = 8'h40; resp_wr++;
    send_req(4'd2, 7'h50, 3'd4);
    expect_head("nak", 4'd2, 7'h50);
    expect_wb("nak_stop", 1'b1, 2'd2, 8'h05);
    expect_wb("nak_chk_stop", 1'b0, 2'd2, 8'h00);
    wait_done("nak", 2'd1, dc);
    check("nak_fifo_flushed", 32'(wdata_ready), 1);
    tick(3);
    check("nak_err_code_hold", 32'(err_code), 1);

    // Arbitration lost after START: no STOP, no further cycles
    resp_mem[resp_wr] = 8'h80; resp_wr++;
    resp_mem[resp_wr] = 8'h20; resp_wr++;
    send_req(4'd1, 7'h11, 3'd1);
    expect_wb("al_dpr_bus", 1'b1, 2'd1, 8'h01);
    expect_wb("al_cmd_setbus", 1'b1, 2'd2, 8'h06);
    expect_wb("al_chk1", 1'b0, 2'd2, 8'h00);
    expect_wb("al_cmd_start", 1'b1, 2'd2, 8'h04);
    expect_wb("al_chk2", 1'b0, 2'd2, 8'h00);
    wait_done("al", 2'd2, dc);
    sz = wb_log.size();
    tick(20);
    check("al_no_more_wb", 32'(wb_log.size()), 32'(sz));

    // irq timeout after SET_BUS
    irq_en = 1'b0;
    send_req(4'd3, 7'h01, 3'd1);
    expect_wb("tmo_dpr_bus", 1'b1, 2'd1, 8'h03);
    expect_wb("tmo_cmd_setbus", 1'b1, 2'd2, 8'h06);
    wait_done("tmo", 2'd3, dc);
    check("tmo_latency", dc - wait_entry, 16);
    sz = wb_log.size();
    tick(20);
    check("tmo_no_more_wb", 32'(wb_log.size()), 32'(sz));
    irq_en = 1'b1;

    // Reset while a DATA-phase DPR write is stalled on the bus
    push_byte(8'h9A);
    push_byte(8'hBC);
    push_byte(8'hDE);
    check("rst_t_fifo_3", 32'(wdata_ready), 1);
    push_byte(8'hF0);
    check("rst_t_fifo_4", 32'(wdata_ready), 0);
    hold_en = 1'b1;
    hold_dat = 8'h9A;
    send_req(4'd4, 7'h33, 3'd4);
    expect_head("rstx", 4'd4, 7'h33);
    t = 0;
    while (!(cyc === 1'b1 && stb === 1'b1 && adr === 2'd1 && dat_o_w === 8'h9A) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rstx_stb_held", 32'(stb), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstx_cyc", 32'(cyc), 0);
    check("rstx_stb", 32'(stb), 0);
    check("rstx_busy", 32'(busy), 0);
    check("rstx_req_ready", 32'(req_ready), 0);
    check("rstx_fifo_cleared", 32'(wdata_ready), 1);
    tick(1);
    rst = 1'b0;
    hold_en = 1'b0;
    expect_wb("rstx_reinit", 1'b1, 2'd0, 8'hC0);
    tick(5);
    check("rstx_idle_ready", 32'(req_ready), 1);
    check("rstx_fifo_empty", 32'(wdata_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
